// File: rtl/ifu_npc_pkg.sv
// Shared constants and types for the fetch-stage PC unit and IF/ID register.
package ifu_npc_pkg;

  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_BR   = 3'd1;
  localparam logic [2:0] NPC_J    = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;
  localparam logic [2:0] NPC_ERET = 3'd4;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_LO     = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_HI     = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] NOP      = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic        exc;
    logic [4:0]  code;
  } ifid_t;

  // Branches and jumps with a delay slot; eret deliberately excluded.
  function automatic logic has_slot(input logic [2:0] op);
    return (op == NPC_BR) || (op == NPC_J) || (op == NPC_JR);
  endfunction

endpackage

// File: rtl/ifu_npc_if.sv
// Fetch-unit bus: ID/CP0 control inputs, instruction memory port and IF/ID outputs.
interface ifu_npc_if;
  logic        stall;
  logic        if_br;
  logic [2:0]  npc_op;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] rs_data;
  logic [31:0] epc;
  logic        exc_req;
  logic [31:0] im_rdata;
  logic [31:0] im_addr;
  logic [31:0] d_instr_out;
  logic [31:0] d_pc_out;
  logic        d_bd;
  logic        d_exc;
  logic [4:0]  d_exc_code;

  modport slave (
    input  stall, if_br, npc_op, d_instr, d_pc, rs_data, epc, exc_req, im_rdata,
    output im_addr, d_instr_out, d_pc_out, d_bd, d_exc, d_exc_code
  );

  modport master (
    output stall, if_br, npc_op, d_instr, d_pc, rs_data, epc, exc_req, im_rdata,
    input  im_addr, d_instr_out, d_pc_out, d_bd, d_exc, d_exc_code
  );
endinterface

// File: rtl/ifu_npc_npc_calc.sv
// Combinational next-PC target mux; branch/jump targets are relative to the ID-stage PC.
module npc_calc
  import ifu_npc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] d_pc,
  input  logic [25:0] imm26,
  input  logic        if_br,
  input  logic [2:0]  npc_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] epc,
  output logic [31:0] npc
);

  logic [31:0] pc_seq;
  logic [31:0] d_pc_seq;
  logic [31:0] br_off;

  assign pc_seq   = pc + 32'd4;
  assign d_pc_seq = d_pc + 32'd4;
  assign br_off   = {{14{imm26[15]}}, imm26[15:0], 2'b00};

  always_comb begin
    npc = pc_seq;
    case (npc_op)
      NPC_BR:   npc = if_br ? (d_pc_seq + br_off) : pc_seq;
      NPC_J:    npc = {d_pc_seq[31:28], imm26, 2'b00};
      NPC_JR:   npc = rs_data;
      NPC_ERET: npc = epc;
      default:  npc = pc_seq;
    endcase
  end

endmodule

// File: rtl/ifu_npc.sv
// Fetch-stage PC register, fetch address check and IF/ID pipeline register.
module ifu_npc
  import ifu_npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] EXC_ENTRY = DEF_EXC_ENTRY,
  parameter logic [31:0] IM_LO     = DEF_IM_LO,
  parameter logic [31:0] IM_HI     = DEF_IM_HI
) (
  input  logic       clk,
  input  logic       reset,
  ifu_npc_if.slave   bus
);

  logic [31:0] pc;
  logic [31:0] npc;
  logic        fetch_exc;
  ifid_t       ifid;
  ifid_t       fetched;
  logic        unused_instr_hi;

  npc_calc u_npc_calc (
    .pc      (pc),
    .d_pc    (bus.d_pc),
    .imm26   (bus.d_instr[25:0]),
    .if_br   (bus.if_br),
    .npc_op  (bus.npc_op),
    .rs_data (bus.rs_data),
    .epc     (bus.epc),
    .npc     (npc)
  );

  // Opcode bits are not needed for target calculation.
  assign unused_instr_hi = ^bus.d_instr[31:26];

  assign fetch_exc = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

  // A faulting fetch becomes a nop tagged with AdEL; memory data is discarded.
  always_comb begin
    fetched.instr = fetch_exc ? NOP : bus.im_rdata;
    fetched.pc    = pc;
    fetched.bd    = has_slot(bus.npc_op);
    fetched.exc   = fetch_exc;
    fetched.code  = fetch_exc ? EXC_ADEL : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= RESET_PC;
      ifid <= '0;
    end else if (bus.exc_req) begin
      pc   <= EXC_ENTRY;
      ifid <= '0;
    end else if (!bus.stall) begin
      pc <= npc;
      // eret has no delay slot, so the instruction fetched behind it is squashed.
      if (bus.npc_op == NPC_ERET) ifid <= '0;
      else                        ifid <= fetched;
    end
  end

  assign bus.im_addr     = pc;
  assign bus.d_instr_out = ifid.instr;
  assign bus.d_pc_out    = ifid.pc;
  assign bus.d_bd        = ifid.bd;
  assign bus.d_exc       = ifid.exc;
  assign bus.d_exc_code  = ifid.code;

endmodule

// File: tb/tb_ifu_npc.sv
// Bench for ifu_npc: directed walk through the fetch scenarios, then randomized cycles vs a reference model.
module tb_ifu_npc;

  logic clk;
  logic reset;
  ifu_npc_if bus();

  ifu_npc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_pc, m_instr, m_dpc;
  logic        m_bd, m_exc;
  logic [4:0]  m_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Next state from the behavioural rules, using the inputs present at the clock edge.
  task automatic model_step();
    logic        legal;
    logic [31:0] off;
    if (reset) begin
      m_pc = 32'h3000; m_instr = 0; m_dpc = 0; m_bd = 0; m_exc = 0; m_code = 0;
    end else if (bus.exc_req) begin
      m_pc = 32'h4180; m_instr = 0; m_dpc = 0; m_bd = 0; m_exc = 0; m_code = 0;
    end else if (!bus.stall) begin
      if (bus.npc_op == 3'd4) begin
        m_instr = 0; m_dpc = 0; m_bd = 0; m_exc = 0; m_code = 0;
        m_pc = bus.epc;
      end else begin
        legal   = (m_pc % 4 == 0) && (m_pc >= 32'h3000) && (m_pc <= 32'h6FFC);
        m_instr = legal ? bus.im_rdata : 32'h0;
        m_dpc   = m_pc;
        m_bd    = (bus.npc_op >= 3'd1) && (bus.npc_op <= 3'd3);
        m_exc   = !legal;
        m_code  = legal ? 5'd0 : 5'd4;
        off     = 32'($signed(bus.d_instr[15:0]));
        case (bus.npc_op)
          3'd1:    m_pc = bus.if_br ? bus.d_pc + 32'd4 + off * 32'd4 : m_pc + 32'd4;
          3'd2:    m_pc = ((bus.d_pc + 32'd4) & 32'hF000_0000) + {4'h0, bus.d_instr[25:0], 2'b00};
          3'd3:    m_pc = bus.rs_data;
          default: m_pc = m_pc + 32'd4;
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("im_addr", bus.im_addr, m_pc);
    chk("d_instr_out", bus.d_instr_out, m_instr);
    chk("d_pc_out", bus.d_pc_out, m_dpc);
    chk("d_bd", 32'(bus.d_bd), 32'(m_bd));
    chk("d_exc", 32'(bus.d_exc), 32'(m_exc));
    chk("d_exc_code", 32'(bus.d_exc_code), 32'(m_code));
  endtask

  task automatic idle_inputs();
    reset = 0; bus.stall = 0; bus.if_br = 0; bus.npc_op = 3'd0; bus.exc_req = 0;
    bus.d_instr = 0; bus.d_pc = 0; bus.rs_data = 0; bus.epc = 0;
    bus.im_rdata = 32'h2408_0001;
  endtask

  logic [31:0] hold_pc, hold_instr;

  initial begin
    m_pc = 0; m_instr = 0; m_dpc = 0; m_bd = 0; m_exc = 0; m_code = 0;
    idle_inputs();
    reset = 1;
    step();
    chk("rst_pc", bus.im_addr, 32'h3000);
    chk("rst_ifid", bus.d_pc_out | bus.d_instr_out, 32'h0);
    reset = 0;

    step(); step(); step();
    chk("seq_pc", bus.im_addr, 32'h300C);
    chk("seq_dpc", bus.d_pc_out, 32'h3008);
    chk("seq_instr", bus.d_instr_out, 32'h2408_0001);
    step();

    // Taken branch from ID at 0x3008, offset -2 words.
    bus.npc_op = 3'd1; bus.if_br = 1; bus.d_pc = 32'h3008; bus.d_instr = 32'h1000_FFFE;
    step();
    chk("br_taken_pc", bus.im_addr, 32'h3004);
    chk("br_slot_bd", 32'(bus.d_bd), 32'd1);
    chk("br_slot_pc", bus.d_pc_out, 32'h3010);
    bus.if_br = 0;
    step();
    chk("br_nt_pc", bus.im_addr, 32'h3008);
    chk("br_nt_bd", 32'(bus.d_bd), 32'd1);

    bus.npc_op = 3'd3; bus.rs_data = 32'h3020;
    step();
    bus.npc_op = 3'd0;
    step();
    hold_pc = bus.d_pc_out; hold_instr = bus.d_instr_out;
    bus.stall = 1; bus.im_rdata = 32'hDEAD_BEEF;
    step(); step();
    chk("stall_pc", bus.im_addr, 32'h3024);
    chk("stall_dpc", bus.d_pc_out, hold_pc);
    chk("stall_instr", bus.d_instr_out, hold_instr);
    bus.stall = 0;
    step();
    chk("resume_pc", bus.im_addr, 32'h3028);

    bus.npc_op = 3'd3; bus.rs_data = 32'h3002;
    step();
    chk("jr_pc", bus.im_addr, 32'h3002);
    bus.npc_op = 3'd0;
    step();
    chk("adel_exc", 32'(bus.d_exc), 32'd1);
    chk("adel_code", 32'(bus.d_exc_code), 32'd4);
    chk("adel_instr", bus.d_instr_out, 32'h0);
    chk("adel_dpc", bus.d_pc_out, 32'h3002);

    bus.exc_req = 1; bus.stall = 1;
    step();
    chk("exc_pc", bus.im_addr, 32'h4180);
    chk("exc_flush", bus.d_pc_out | bus.d_instr_out | 32'(bus.d_bd), 32'h0);
    bus.exc_req = 0; bus.stall = 0;
    bus.npc_op = 3'd4; bus.epc = 32'h3040;
    step();
    chk("eret_pc", bus.im_addr, 32'h3040);
    chk("eret_bubble", bus.d_pc_out | bus.d_instr_out | 32'(bus.d_bd), 32'h0);

    bus.npc_op = 3'd2; bus.d_pc = 32'h3FFC; bus.d_instr = 32'h0800_0C10;
    step();
    chk("j_pc", bus.im_addr, 32'h3040);
    bus.npc_op = 3'd3; bus.rs_data = 32'h7000;
    step();
    bus.npc_op = 3'd0;
    step();
    chk("hi_adel_code", 32'(bus.d_exc_code), 32'd4);
    chk("hi_adel_dpc", bus.d_pc_out, 32'h7000);

    for (int i = 0; i < 500; i++) begin
      reset       = ($urandom_range(0, 99) < 2);
      bus.exc_req = ($urandom_range(0, 99) < 5);
      bus.stall   = ($urandom_range(0, 99) < 15);
      bus.npc_op  = 3'($urandom_range(0, 7));
      bus.if_br   = 1'($urandom_range(0, 1));
      bus.d_pc    = 32'h3000 + 32'($urandom_range(0, 'hFFF)) * 4;
      bus.d_instr = $urandom;
      if ($urandom_range(0, 3) != 0) bus.d_instr[25:0] = 26'($urandom_range('hC00, 'h1BFF));
      bus.rs_data = ($urandom_range(0, 3) != 0) ? 32'h3000 + 32'($urandom_range(0, 'hFFF)) * 4 : $urandom;
      bus.epc     = ($urandom_range(0, 3) != 0) ? 32'h3000 + 32'($urandom_range(0, 'hFFF)) * 4 : $urandom;
      bus.im_rdata = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
